cnna_mul_pipe: RTL
==================

CNNA_MUL_PIPE -- requirements
Module: cnna_mul_pipe

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 8, width of operand A.
REQ-002 SHALL have parameter DIN1_WIDTH, default 27, width of operand B.
REQ-003 SHALL have parameter DOUT_WIDTH, default 35, result width.
REQ-004 SHALL have parameter NUM_STAGE, default 3, pipeline depth in cycles, legal range 1..6.
REQ-005 SHALL have port ap_clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port ap_rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1, operand beat valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-009 SHALL have port din0, input, DIN0_WIDTH, operand A.
REQ-010 SHALL have port din1, input, DIN1_WIDTH, operand B.
REQ-011 SHALL have port din0_signed, input, 1, A is two's complement when 1, unsigned when 0.
REQ-012 SHALL have port din1_signed, input, 1, B is two's complement when 1, unsigned when 0.
REQ-013 SHALL have port out_valid, output, 1, result valid.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-015 SHALL have port dout, output, DOUT_WIDTH, result.

Function
REQ-016 SHALL transfer an input beat when in_valid and in_ready are both 1, and an output beat when out_valid and out_ready are both 1.
REQ-017 SHALL capture din0_signed and din1_signed with their operands, so mode may change on every beat.
REQ-018 SHALL compute the full product at width DIN0_WIDTH+DIN1_WIDTH, extending each operand by its own signed flag.
REQ-019 SHALL, when DOUT_WIDTH is narrower than the full product, output its low DOUT_WIDTH bits (wrap, no saturation); when wider, output the product sign-extended if either flag is 1, else zero-extended.
REQ-020 SHALL present a beat accepted in cycle N on dout with out_valid=1 in cycle N+NUM_STAGE when no stall occurs.
REQ-021 SHALL hold a valid bit per stage; each stage advances when it is empty or the stage after it advances. Bubbles SHALL collapse under stall.
REQ-022 SHALL drive in_ready=1 whenever stage 1 is empty or advances; in_ready SHALL NOT depend combinationally on in_valid.
REQ-023 SHALL hold dout and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL sustain one result per cycle with out_ready held at 1, and SHALL never drop or duplicate a beat.
REQ-025 SHALL compute the extreme case -2^(W-1) x -2^(W-1), both operands signed, exactly within the full product width.

Reset
REQ-026 SHALL, while ap_rst_n=0, clear all stage valid bits, drive out_valid=0 and dout=0, and discard in-flight beats.
REQ-027 SHALL drive in_ready=1 from the first clock edge after reset is released.
REQ-028 SHALL leave datapath registers other than dout free of reset.

Configuration
REQ-029 SHALL, when macro CNNA_MUL_ACC_EN is defined, add input acc_first (1 bit, sampled with the beat): dout = product when acc_first=1, otherwise the previous output result plus product, at DOUT_WIDTH with wrap. Reset SHALL clear the accumulator to 0.
REQ-030 SHALL, when CNNA_MUL_ACC_EN is undefined, have no acc_first port and no accumulator, and behave per REQ-018..REQ-025.

Structure
REQ-031 SHALL place a shared package holding the width-derivation constants (full product width), stage-count limits, and the signed-mode enum.
REQ-032 SHALL contain one sub-module, cnna_mul_pipe_stage: one register stage with valid, a data payload and advance logic, instantiated NUM_STAGE times.

Verification
REQ-033 SHALL cover the default widths: din0=255, din1=134217727, both flags 0, out_ready=1 -> dout=34225520385 (0x7F7FFFF01) exactly 3 cycles after acceptance.
REQ-034 SHALL cover signed mode: din0=8'h80 (-128) signed, din1=27'h7FFFFFF (-1) signed -> dout=128, and, with din1 unsigned, -> dout=-17179869056 as 35-bit two's complement.
REQ-035 SHALL cover backpressure: 10 back-to-back beats with out_ready low for cycles 4..8 -> all 10 results delivered in order, dout held stable during the stall, in_ready=0 once the pipeline is full.
REQ-036 SHALL cover truncation: DOUT_WIDTH=16 with 0xFF x 0x101 unsigned -> dout=0xFFFF; 0x100 x 0x100 -> dout=0x0000.
REQ-037 SHALL cover reset mid-operation: ap_rst_n pulled low with 3 beats in flight -> out_valid=0 immediately, and no stale result appears after release.
REQ-038 SHALL cover CNNA_MUL_ACC_EN: beats (3x4, first=1), (2x5), (1x1) -> dout sequence 12, 22, 23; a new first=1 beat restarts the sum.

Source files
------------

// File: rtl/cnna_mul_pipe_pkg.sv
// cnna_mul_pipe_pkg -- shared definitions for the pipelined multiplier.
//   - product width derivation (prod_width)
//   - legal pipeline depth limits
//   - signed-mode enum, encoded as {din0_signed, din1_signed}
//   - ACC_BITS: payload bits reserved for the accumulate flag; this is 1 when
//     CNNA_MUL_ACC_EN is defined and 0 otherwise
package cnna_mul_pipe_pkg;

  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 6;

`ifdef CNNA_MUL_ACC_EN
  localparam int ACC_BITS = 1;
`else
  localparam int ACC_BITS = 0;
`endif

  typedef enum logic [1:0] {
    MODE_UU = 2'b00,
    MODE_US = 2'b01,
    MODE_SU = 2'b10,
    MODE_SS = 2'b11
  } mode_e;

  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/cnna_mul_pipe_stage.sv
// cnna_mul_pipe_stage -- a single valid/ready register stage.
// The stage accepts a new beat whenever it is empty or its current beat
// leaves this cycle. Because of this rule, bubbles collapse under a stall.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (clears valid)
//   up_valid    upstream beat valid
//   up_data     upstream payload
//   up_ready    stage can take a beat this cycle
//   down_ready  downstream takes our beat this cycle
//   valid       stage holds a beat
//   data        stage payload
// Parameters: W (payload width).
//             RESET_DATA (set to 1 to also clear the payload on reset).
module cnna_mul_pipe_stage #(
  parameter int W          = 8,
  parameter bit RESET_DATA = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         up_ready,
  input  logic         down_ready,
  output logic         valid,
  output logic [W-1:0] data
);

  assign up_ready = !valid || down_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid <= 1'b0;
    else if (up_ready) valid <= up_valid;
  end

  if (RESET_DATA) begin : g_data_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data <= '0;
      else if (up_ready && up_valid) data <= up_data;
    end
  end else begin : g_data_norst
    // NOTE: the payload is meaningless while valid is 0. For that reason it
    // has no reset, which keeps the reset net off the wide datapath flops.
    always_ff @(posedge clk) begin
      if (up_ready && up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/cnna_mul_pipe.sv
// cnna_mul_pipe -- valid/ready multiplier with NUM_STAGE register stages.
// Each operand is extended by its own signed flag to the full product width.
// The result is truncated (wrap) or extended to DOUT_WIDTH. If either
// operand is signed, the extension is a sign extension.
// Latency is NUM_STAGE cycles without stalls, and throughput is one beat
// per cycle.
// Ports:
//   ap_clk, ap_rst_n           clock and asynchronous active-low reset
//   in_valid/in_ready          operand handshake
//   din0, din1                 operands A and B
//   din0_signed, din1_signed   per-beat signed mode flags
//   acc_first                  present only with CNNA_MUL_ACC_EN.
//                              1 = start a new sum, 0 = add the product to
//                              the previous result.
//   out_valid/out_ready, dout  result handshake and value
// Optional feature macro: CNNA_MUL_ACC_EN (adds the running accumulator).
module cnna_mul_pipe
  import cnna_mul_pipe_pkg::*;
#(
  parameter int DIN0_WIDTH = 8,
  parameter int DIN1_WIDTH = 27,
  parameter int DOUT_WIDTH = 35,
  parameter int NUM_STAGE  = 3
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  din0_signed,
  input  logic                  din1_signed,
`ifdef CNNA_MUL_ACC_EN
  input  logic                  acc_first,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout
);

  localparam int PW    = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  // Payload layout: [PW-1:0] product, [PW] sign-extend flag, [PW+1] acc_first.
  localparam int PAY_W = PW + 1 + ACC_BITS;

  if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_cfg
    $error("cnna_mul_pipe: NUM_STAGE out of range 1..6");
  end

  mode_e           mode;
  logic            a_sgn, b_sgn;
  logic [PW-1:0]   a_ext, b_ext, prod;
  logic [PAY_W-1:0] pay_in;

  assign mode  = mode_e'({din0_signed, din1_signed});
  assign a_sgn = (mode == MODE_SU) || (mode == MODE_SS);
  assign b_sgn = (mode == MODE_US) || (mode == MODE_SS);
  assign a_ext = {{DIN1_WIDTH{a_sgn & din0[DIN0_WIDTH-1]}}, din0};
  assign b_ext = {{DIN0_WIDTH{b_sgn & din1[DIN1_WIDTH-1]}}, din1};
  // Both operands are extended to PW, so the low PW bits of the product are
  // exact for every mode, including -2^(W-1) x -2^(W-1).
  assign prod  = a_ext * b_ext;

  assign pay_in[PW-1:0] = prod;
  assign pay_in[PW]     = a_sgn | b_sgn;
`ifdef CNNA_MUL_ACC_EN
  assign pay_in[PW+1]   = acc_first;
`endif

  // Handshake chain. Index 0 is the input port. rdy[NUM_STAGE] is out_ready.
  logic [NUM_STAGE-1:0]            vld;
  logic [NUM_STAGE:0]              rdy;
  logic [NUM_STAGE-1:0][PAY_W-1:0] pay;

  assign vld[0]         = in_valid;
  assign pay[0]         = pay_in;
  assign rdy[NUM_STAGE] = out_ready;
  assign in_ready       = rdy[0];

  for (genvar i = 0; i < NUM_STAGE - 1; i++) begin : g_mid
    cnna_mul_pipe_stage #(.W(PAY_W), .RESET_DATA(1'b0)) u_stage (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .up_valid  (vld[i]),
      .up_data   (pay[i]),
      .up_ready  (rdy[i]),
      .down_ready(rdy[i+1]),
      .valid     (vld[i+1]),
      .data      (pay[i+1])
    );
  end

  // The last stage stores the formatted result, so its register is dout.
  logic [PW-1:0]         last_prod;
  logic                  last_sx;
  logic [DOUT_WIDTH-1:0] fmt, result;

  assign last_prod = pay[NUM_STAGE-1][PW-1:0];
  assign last_sx   = pay[NUM_STAGE-1][PW];

  if (DOUT_WIDTH <= PW) begin : g_trunc
    logic unused_sx;
    assign unused_sx = last_sx;
    assign fmt       = last_prod[DOUT_WIDTH-1:0];
  end else begin : g_ext
    assign fmt = {{(DOUT_WIDTH-PW){last_sx & last_prod[PW-1]}}, last_prod};
  end

`ifdef CNNA_MUL_ACC_EN
  // dout still holds the previously delivered result when the next beat
  // loads, so dout itself serves as the accumulator register.
  assign result = pay[NUM_STAGE-1][PW+1] ? fmt : dout + fmt;
`else
  assign result = fmt;
`endif

  cnna_mul_pipe_stage #(.W(DOUT_WIDTH), .RESET_DATA(1'b1)) u_last (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .up_valid  (vld[NUM_STAGE-1]),
    .up_data   (result),
    .up_ready  (rdy[NUM_STAGE-1]),
    .down_ready(rdy[NUM_STAGE]),
    .valid     (out_valid),
    .data      (dout)
  );

endmodule
